// File: rtl/demux_seq_pkg.sv
// Shared types and sizing for the DeMUX lane sequencer.
package demux_seq_pkg;

  localparam int unsigned LANES_DEFAULT = 8;
  localparam int unsigned SEL_W_DEFAULT = $clog2(LANES_DEFAULT);

  typedef enum logic [1:0] {
    StIdle,
    StRoute,
    StHold
  } seq_state_e;

endpackage

// File: rtl/next_lane_finder.sv
// Combinational search for the next enabled lane: either the lowest set bit of the
// mask (first=1) or the lowest set bit strictly above cur (first=0).
module next_lane_finder
  import demux_seq_pkg::*;
#(
  parameter int unsigned LANES = LANES_DEFAULT,
  localparam int unsigned SEL_W = $clog2(LANES)
) (
  input  logic [LANES-1:0] mask,
  input  logic [SEL_W-1:0] cur,
  input  logic             first,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  // Scan from the top down so the lowest qualifying lane is the one left standing.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask[i] && (first || (i > int'(cur)))) begin
        idx   = SEL_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_lane_sequencer.sv
// Masked serial-to-parallel deserializer that drives a 1:LANES DeMUX, one bit per
// enabled lane, and holds the assembled word until the consumer takes it.
module demux_lane_sequencer
  import demux_seq_pkg::*;
#(
  parameter int unsigned LANES = LANES_DEFAULT,
  localparam int unsigned SEL_W = $clog2(LANES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LANES-1:0] lane_mask,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             dm_en,
  output logic             dm_in,
  output logic [SEL_W-1:0] dm_sel,
  output logic [LANES-1:0] word,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic             err_mask
);

  seq_state_e       state_q, state_d;
  logic [LANES-1:0] mask_q, mask_d;
  logic [LANES-1:0] cap_q, cap_d;
  logic [SEL_W-1:0] lane_q, lane_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             err_q, err_d;

  logic [SEL_W-1:0] first_idx, adv_idx;
  logic             first_found, adv_found;
  logic             xfer;

  // Lowest enabled lane of the incoming mask, used when a word is started.
  next_lane_finder #(
    .LANES(LANES)
  ) u_first_finder (
    .mask (lane_mask),
    .cur  ('0),
    .first(1'b1),
    .idx  (first_idx),
    .found(first_found)
  );

  // Next enabled lane above the current one within the latched mask.
  next_lane_finder #(
    .LANES(LANES)
  ) u_adv_finder (
    .mask (mask_q),
    .cur  (lane_q),
    .first(1'b0),
    .idx  (adv_idx),
    .found(adv_found)
  );

  assign xfer = (state_q == StRoute) && in_valid;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: latched mask, capture word, lane pointer, held select, error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= '0;
      cap_q  <= '0;
      lane_q <= '0;
      sel_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      cap_q  <= cap_d;
      lane_q <= lane_d;
      sel_q  <= sel_d;
      err_q  <= err_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cap_d   = cap_q;
    lane_d  = lane_q;
    sel_d   = sel_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (first_found) begin
            mask_d  = lane_mask;
            cap_d   = '0;
            lane_d  = first_idx;
            state_d = StRoute;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StRoute: begin
        if (xfer) begin
          cap_d[lane_q] = in_bit;
          sel_d         = lane_q;
          if (adv_found) begin
            lane_d = adv_idx;
          end else begin
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (word_ready) begin
          state_d = StIdle;
          // Back-to-back word start without passing through idle.
          if (start) begin
            if (first_found) begin
              mask_d  = lane_mask;
              cap_d   = '0;
              lane_d  = first_idx;
              state_d = StRoute;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode; the DeMUX select keeps the last routed lane while idle.
  always_comb begin
    in_ready   = (state_q == StRoute);
    dm_en      = xfer;
    dm_in      = xfer ? in_bit : 1'b0;
    dm_sel     = xfer ? lane_q : sel_q;
    word_valid = (state_q == StHold);
    word       = (state_q == StHold) ? cap_q : '0;
    busy       = (state_q != StIdle);
    err_mask   = err_q;
  end

endmodule

// File: tb/tb_demux_lane_sequencer.sv
// Directed self-checking bench for demux_lane_sequencer.
module tb_demux_lane_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] lane_mask;
  logic       in_bit;
  logic       in_valid;
  logic       in_ready;
  logic       dm_en;
  logic       dm_in;
  logic [2:0] dm_sel;
  logic [7:0] word;
  logic       word_valid;
  logic       word_ready;
  logic       busy;
  logic       err_mask;

  int total = 0;
  int bad   = 0;

  demux_lane_sequencer #(
    .LANES(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .lane_mask (lane_mask),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dm_en     (dm_en),
    .dm_in     (dm_in),
    .dm_sel    (dm_sel),
    .word      (word),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .busy      (busy),
    .err_mask  (err_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle sample point for combinational outputs.
  task automatic settle();
    #4;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".in_ready"}, 32'(in_ready), 32'd0);
    check({tag, ".dm_en"}, 32'(dm_en), 32'd0);
    check({tag, ".dm_in"}, 32'(dm_in), 32'd0);
    check({tag, ".dm_sel"}, 32'(dm_sel), 32'd0);
    check({tag, ".word"}, 32'(word), 32'd0);
    check({tag, ".word_valid"}, 32'(word_valid), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".err_mask"}, 32'(err_mask), 32'd0);
  endtask

  logic [7:0] bits_a;
  logic [2:0] b_lanes [3];

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    lane_mask  = '0;
    in_bit     = 1'b0;
    in_valid   = 1'b0;
    word_ready = 1'b0;
    tick();
    tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // Full mask, bits 1,0,1,1,0,0,1,0 on lanes 0..7.
    bits_a    = 8'b0100_1101;
    start     = 1'b1;
    lane_mask = 8'hFF;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_bit   = bits_a[i];
      settle();
      check($sformatf("full.en%0d", i), 32'(dm_en), 32'd1);
      check($sformatf("full.sel%0d", i), 32'(dm_sel), 32'(i));
      check($sformatf("full.din%0d", i), 32'(dm_in), 32'(bits_a[i]));
      check($sformatf("full.wv%0d", i), 32'(word_valid), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    settle();
    check("full.word_valid", 32'(word_valid), 32'd1);
    check("full.word", 32'(word), 32'h4D);
    check("full.in_ready", 32'(in_ready), 32'd0);
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    settle();
    check("full.after_word", 32'(word), 32'd0);
    check("full.after_busy", 32'(busy), 32'd0);
    check("full.after_wv", 32'(word_valid), 32'd0);
    tick();

    // Sparse mask 1010_0100 with gaps; a start with another mask mid-word is ignored.
    b_lanes[0] = 3'd2;
    b_lanes[1] = 3'd5;
    b_lanes[2] = 3'd7;
    start     = 1'b1;
    lane_mask = 8'b1010_0100;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid  = 1'b0;
      in_bit    = 1'b1;
      start     = 1'b1;
      lane_mask = 8'h0F;
      settle();
      check($sformatf("sparse.gap_en%0d", k), 32'(dm_en), 32'd0);
      check($sformatf("sparse.gap_rdy%0d", k), 32'(in_ready), 32'd1);
      tick();
      start    = 1'b0;
      in_valid = 1'b1;
      settle();
      check($sformatf("sparse.en%0d", k), 32'(dm_en), 32'd1);
      check($sformatf("sparse.sel%0d", k), 32'(dm_sel), 32'(b_lanes[k]));
      tick();
    end
    in_valid  = 1'b0;
    lane_mask = 8'h00;
    settle();
    check("sparse.dm_sel_hold", 32'(dm_sel), 32'd7);
    check("sparse.word_valid", 32'(word_valid), 32'd1);
    check("sparse.word", 32'(word), 32'hA4);
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    tick();

    // Zero mask start: one-cycle error pulse, no activity.
    start     = 1'b1;
    lane_mask = 8'h00;
    tick();
    start = 1'b0;
    settle();
    check("zmask.err", 32'(err_mask), 32'd1);
    check("zmask.busy", 32'(busy), 32'd0);
    check("zmask.dm_en", 32'(dm_en), 32'd0);
    tick();
    check("zmask.err_clear", 32'(err_mask), 32'd0);

    // Mask 1000_0001 -> word 0x80, held under backpressure, then back-to-back start.
    start     = 1'b1;
    lane_mask = 8'h81;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_bit   = 1'b0;
    tick();
    in_bit = 1'b1;
    settle();
    check("bp.sel7", 32'(dm_sel), 32'd7);
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      settle();
      check($sformatf("bp.word%0d", c), 32'(word), 32'h80);
      check($sformatf("bp.rdy%0d", c), 32'(in_ready), 32'd0);
      check($sformatf("bp.wv%0d", c), 32'(word_valid), 32'd1);
      tick();
    end
    word_ready = 1'b1;
    start      = 1'b1;
    lane_mask  = 8'h01;
    tick();
    word_ready = 1'b0;
    start      = 1'b0;
    settle();
    check("b2b.busy", 32'(busy), 32'd1);
    check("b2b.in_ready", 32'(in_ready), 32'd1);
    check("b2b.word_valid", 32'(word_valid), 32'd0);
    check("b2b.word", 32'(word), 32'd0);
    in_valid = 1'b1;
    in_bit   = 1'b1;
    tick();
    in_valid = 1'b0;
    settle();
    check("b2b.word_out", 32'(word), 32'h01);
    check("b2b.wv_out", 32'(word_valid), 32'd1);
    // Release with a zero-mask start: back to idle with an error pulse.
    word_ready = 1'b1;
    start      = 1'b1;
    lane_mask  = 8'h00;
    tick();
    word_ready = 1'b0;
    start      = 1'b0;
    settle();
    check("hold_zmask.err", 32'(err_mask), 32'd1);
    check("hold_zmask.busy", 32'(busy), 32'd0);
    tick();

    // Asynchronous reset in the middle of a full-mask word.
    start     = 1'b1;
    lane_mask = 8'hFF;
    tick();
    start = 1'b0;
    for (int j = 0; j < 3; j++) begin
      in_valid = 1'b1;
      in_bit   = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    settle();
    check("midrst.busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst.async_busy", 32'(busy), 32'd0);
    tick();
    check_idle_outputs("midrst");
    rst = 1'b0;
    tick();
    check_idle_outputs("postrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
